// File: rtl/req_encoder_4to2_pkg.sv
// Shared types and constants for the request encoder: FSM encoding, default sizes and
// the fixed priority order (highest-numbered line wins).
package req_encoder_4to2_pkg;

  localparam int unsigned NUM_REQ_DEF = 4;
  localparam int unsigned IDX_W_DEF   = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } state_e;

  // Returns {any_set, index}; scanning upward lets the highest set line overwrite lower ones.
  function automatic logic [2:0] prio4(input logic [3:0] vec);
    logic [1:0] idx;
    logic       any;
    idx = 2'd0;
    any = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (vec[i]) begin
        idx = 2'(i);
        any = 1'b1;
      end
    end
    return {any, idx};
  endfunction

endpackage

// File: rtl/req_encoder_4to2_prio_enc4.sv
// Combinational 4-line priority encoder, line 3 highest; zero latency, no flow control.
module req_encoder_4to2_prio_enc4
  import req_encoder_4to2_pkg::*;
(
  input  logic [3:0] vec_i,
  output logic [1:0] idx_o,
  output logic       any_o
);

  logic [2:0] enc;

  assign enc   = prio4(vec_i);
  assign idx_o = enc[1:0];
  assign any_o = enc[2];

endmodule

// File: rtl/req_encoder_4to2.sv
// Accumulates request pulses into a pending vector and offers the highest pending index.
// REQ->VALID is 2 cycles from idle; an offer is held until ACK, then one IDLE bubble follows.
module req_encoder_4to2
  import req_encoder_4to2_pkg::*;
#(
  parameter int unsigned NUM_REQ = NUM_REQ_DEF,
  parameter int unsigned IDX_W   = IDX_W_DEF
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic [NUM_REQ-1:0] REQ,
  input  logic               CLR,
  input  logic               ACK,
  output logic [IDX_W-1:0]   A,
  output logic               VALID,
  output logic [NUM_REQ-1:0] PEND,
  output logic               OVF
);

  state_e             state_q;
  logic [IDX_W-1:0]   a_q;
  logic               valid_q;
  logic [NUM_REQ-1:0] pend_q;
  logic               ovf_q;

  logic [NUM_REQ-1:0] served;
  logic [NUM_REQ-1:0] pend_d;
  logic               ovf_d;
  logic [IDX_W-1:0]   enc_idx;
  logic               enc_any;

  req_encoder_4to2_prio_enc4 u_prio (
    .vec_i (pend_q),
    .idx_o (enc_idx),
    .any_o (enc_any)
  );

  // A same-cycle request on the line being served is a fresh request, not an overflow.
  always_comb begin
    served = '0;
    if (valid_q && ACK) begin
      served[a_q] = 1'b1;
    end
    pend_d = (pend_q & ~served) | REQ;
    ovf_d  = ovf_q | (|(REQ & pend_q & ~served));
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      a_q     <= '0;
      valid_q <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else if (CLR) begin
      state_q <= IDLE;
      a_q     <= '0;
      valid_q <= 1'b0;
      pend_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      case (state_q)
        IDLE: begin
          if (enc_any) begin
            a_q     <= enc_idx;
            valid_q <= 1'b1;
            state_q <= OFFER;
          end
        end
        OFFER: begin
          if (ACK) begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign A     = a_q;
  assign VALID = valid_q;
  assign PEND  = pend_q;
  assign OVF   = ovf_q;

endmodule

// File: tb/tb_req_encoder_4to2.sv
// Directed-vector bench for req_encoder_4to2; A is looped through a 2-to-4 decoder model.
module tb_req_encoder_4to2;

  logic       CLK;
  logic       RESET_N;
  logic [3:0] REQ;
  logic       CLR;
  logic       ACK;
  logic [1:0] A;
  logic       VALID;
  logic [3:0] PEND;
  logic       OVF;

  int checks   = 0;
  int failures = 0;

  req_encoder_4to2 dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .REQ     (REQ),
    .CLR     (CLR),
    .ACK     (ACK),
    .A       (A),
    .VALID   (VALID),
    .PEND    (PEND),
    .OVF     (OVF)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  function automatic logic [3:0] dec2to4(input logic [1:0] idx);
    case (idx)
      2'd0:    return 4'b0001;
      2'd1:    return 4'b0010;
      2'd2:    return 4'b0100;
      default: return 4'b1000;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic expect_offer(input string tag, input logic [1:0] exp_idx, input logic [3:0] exp_onehot);
    chk({tag, ".valid"}, 32'(VALID), 32'd1);
    chk({tag, ".a"}, 32'(A), 32'(exp_idx));
    chk({tag, ".dec"}, 32'(dec2to4(A)), 32'(exp_onehot));
  endtask

  task automatic expect_idle(input string tag, input logic [3:0] exp_pend);
    chk({tag, ".valid"}, 32'(VALID), 32'd0);
    chk({tag, ".pend"}, 32'(PEND), 32'(exp_pend));
  endtask

  initial begin
    RESET_N = 1'b0;
    REQ     = 4'b0000;
    CLR     = 1'b0;
    ACK     = 1'b0;
    tick();
    tick();
    chk("rst.valid", 32'(VALID), 32'd0);
    chk("rst.a", 32'(A), 32'd0);
    chk("rst.pend", 32'(PEND), 32'd0);
    chk("rst.ovf", 32'(OVF), 32'd0);
    RESET_N = 1'b1;
    tick();

    // T1: async reset in the middle of an offer, with OVF also set
    REQ = 4'b0100;
    tick();
    tick();
    expect_offer("t1.pre", 2'd2, 4'b0100);
    tick();
    chk("t1.ovf_pre", 32'(OVF), 32'd1);
    REQ = 4'b0000;
    #2;
    RESET_N = 1'b0;
    #1;
    chk("t1.valid", 32'(VALID), 32'd0);
    chk("t1.a", 32'(A), 32'd0);
    chk("t1.pend", 32'(PEND), 32'd0);
    chk("t1.ovf", 32'(OVF), 32'd0);
    tick();
    chk("t1.hold_valid", 32'(VALID), 32'd0);
    RESET_N = 1'b1;
    tick();

    // T2: single request, held offer, acknowledged in cycle 5
    REQ = 4'b0100;
    tick();
    REQ = 4'b0000;
    expect_idle("t2.c1", 4'b0100);
    tick();
    expect_offer("t2.c2", 2'd2, 4'b0100);
    for (int c = 3; c <= 5; c++) begin
      tick();
      expect_offer($sformatf("t2.c%0d", c), 2'd2, 4'b0100);
    end
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    expect_idle("t2.c6", 4'b0000);

    // T3: three lines at once, ACK held high
    REQ = 4'b1011;
    ACK = 1'b1;
    tick();
    REQ = 4'b0000;
    expect_idle("t3.e1", 4'b1011);
    tick();
    expect_offer("t3.g3", 2'd3, 4'b1000);
    tick();
    expect_idle("t3.e3", 4'b0011);
    tick();
    expect_offer("t3.g1", 2'd1, 4'b0010);
    tick();
    expect_idle("t3.e5", 4'b0001);
    tick();
    expect_offer("t3.g0", 2'd0, 4'b0001);
    tick();
    ACK = 1'b0;
    expect_idle("t3.e7", 4'b0000);
    chk("t3.ovf", 32'(OVF), 32'd0);

    // T4: higher-priority request during an offer does not preempt
    REQ = 4'b0010;
    tick();
    REQ = 4'b0000;
    tick();
    expect_offer("t4.g1", 2'd1, 4'b0010);
    REQ = 4'b1000;
    tick();
    REQ = 4'b0000;
    expect_offer("t4.hold", 2'd1, 4'b0010);
    chk("t4.pend", 32'(PEND), 32'b1010);
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    expect_idle("t4.bubble", 4'b1000);
    tick();
    expect_offer("t4.g3", 2'd3, 4'b1000);
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    expect_idle("t4.done", 4'b0000);

    // T5a: repeat request on an unserved pending line sets sticky OVF
    REQ = 4'b0100;
    tick();
    REQ = 4'b0000;
    tick();
    expect_offer("t5a.g2", 2'd2, 4'b0100);
    REQ = 4'b0100;
    tick();
    REQ = 4'b0000;
    chk("t5a.ovf_set", 32'(OVF), 32'd1);
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    expect_idle("t5a.ack", 4'b0000);
    REQ = 4'b0001;
    tick();
    REQ = 4'b0000;
    tick();
    expect_offer("t5a.g0", 2'd0, 4'b0001);
    chk("t5a.ovf_sticky", 32'(OVF), 32'd1);
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    chk("t5a.ovf_after", 32'(OVF), 32'd1);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    chk("t5a.ovf_clr", 32'(OVF), 32'd0);

    // T5b: request coinciding with ACK of the same line is retained, not an overflow
    REQ = 4'b0100;
    tick();
    REQ = 4'b0000;
    tick();
    expect_offer("t5b.g2", 2'd2, 4'b0100);
    REQ = 4'b0100;
    ACK = 1'b1;
    tick();
    REQ = 4'b0000;
    ACK = 1'b0;
    expect_idle("t5b.ack", 4'b0100);
    chk("t5b.ovf", 32'(OVF), 32'd0);
    tick();
    expect_offer("t5b.reoffer", 2'd2, 4'b0100);
    ACK = 1'b1;
    tick();
    ACK = 1'b0;
    expect_idle("t5b.done", 4'b0000);

    // T6: CLR beats a simultaneous REQ and ACK during an offer
    REQ = 4'b0010;
    tick();
    REQ = 4'b0000;
    tick();
    expect_offer("t6.g1", 2'd1, 4'b0010);
    REQ = 4'b0010;
    tick();
    chk("t6.ovf_pre", 32'(OVF), 32'd1);
    REQ = 4'b0001;
    CLR = 1'b1;
    ACK = 1'b1;
    tick();
    REQ = 4'b0000;
    CLR = 1'b0;
    ACK = 1'b0;
    expect_idle("t6.clr", 4'b0000);
    chk("t6.ovf", 32'(OVF), 32'd0);
    chk("t6.a", 32'(A), 32'd0);
    tick();
    expect_idle("t6.after", 4'b0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
